// File: rtl/gray_pkg.sv
// gray_pkg: shared state encoding and Gray conversion for the sweep sequencer
package gray_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: down-counting step timer, expired while the count is zero
module step_prescaler #(
   parameter int DIV_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [DIV_BITS-1:0] load_val,
   input  logic                en,
   output logic                expired
);
   logic [DIV_BITS-1:0] cnt;
   assign expired = (cnt == '0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && !expired) cnt <= cnt - 1'b1;
endmodule

// File: rtl/gray_sweep_sequencer.sv
// gray_sweep_sequencer: steps a binary count start->end at a programmed rate, Gray-encoded output
module gray_sweep_sequencer
   import gray_pkg::*;
#(
   parameter int CLOCK_MHZ = 16,
   parameter int BITS      = 8,
   parameter int DIV_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [BITS-1:0]     cmd_start,
   input  logic [BITS-1:0]     cmd_end,
   input  logic [DIV_BITS-1:0] cmd_div,
   input  logic                abort,
   output logic [BITS-1:0]     value,
   output logic                step,
   output logic                busy,
   output logic                done
);
   state_t state, state_nxt;
   logic [BITS-1:0] bin, bin_nxt, end_r;
   logic [DIV_BITS-1:0] div_r;
   logic dir_up, step_nxt, load, expired;
   assign cmd_ready = (state == IDLE);
   assign busy = (state != IDLE);
   assign done = (state == DONE);
   step_prescaler #(.DIV_BITS(DIV_BITS)) u_presc (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .load_val(state == IDLE ? cmd_div : div_r),
      .en(state == RUN),
      .expired(expired)
   );
   // abort outranks expiry, so an aborted cycle never steps or enters DONE
   always_comb begin
      state_nxt = state;
      bin_nxt = bin;
      step_nxt = 1'b0;
      load = 1'b0;
      if (state == IDLE) begin
         if (cmd_valid) begin
            state_nxt = RUN;
            bin_nxt = cmd_start;
            load = 1'b1;
         end
      end else if (abort || state == DONE) begin
         state_nxt = IDLE;
      end else if (expired) begin
         if (bin != end_r) begin
            bin_nxt = dir_up ? bin + 1'b1 : bin - 1'b1;
            step_nxt = 1'b1;
            load = 1'b1;
         end else begin
            state_nxt = DONE;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         bin <= '0;
         value <= '0;
         step <= 1'b0;
         end_r <= '0;
         div_r <= '0;
         dir_up <= 1'b1;
      end else begin
         state <= state_nxt;
         bin <= bin_nxt;
         value <= BITS'(bin2gray(32'(bin_nxt)));
         step <= step_nxt;
         if (state == IDLE && cmd_valid) begin
            end_r <= cmd_end;
            div_r <= cmd_div;
            dir_up <= (cmd_end >= cmd_start);
         end
      end
endmodule

// File: tb/tb_gray_sweep_sequencer.sv
// tb_gray_sweep_sequencer: directed scenario tests with hand-computed Gray codes
module tb_gray_sweep_sequencer;
   logic clk = 0, rst_n = 0, cmd_valid = 0, abort = 0;
   logic [7:0] cmd_start = 0, cmd_end = 0;
   logic [15:0] cmd_div = 0;
   logic cmd_ready, step, busy, done;
   logic [7:0] value;
   int checks = 0, failures = 0;

   gray_sweep_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_div(cmd_div), .abort(abort),
      .value(value), .step(step), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Presents a command on a negedge; returns #1 after the accepting edge
   task automatic issue(input logic [7:0] s, input logic [7:0] e, input logic [15:0] d);
      @(negedge clk);
      cmd_valid = 1; cmd_start = s; cmd_end = e; cmd_div = d;
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({value, cmd_ready, busy, done, step} !== {8'h00, 4'b1000}) begin
         failures++;
         $display("FAIL reset: value=%h rdy=%b busy=%b done=%b step=%b, want 00 1 0 0 0", value, cmd_ready, busy, done, step);
      end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_up;
      logic [7:0] exp [4] = '{8'h0, 8'h1, 8'h3, 8'h2};
      issue(0, 3, 0);
      checks++;
      if (value !== 8'h0 || step !== 0 || cmd_ready !== 0) begin
         failures++; $display("FAIL up_accept: value=%h step=%b rdy=%b, want 00 0 0", value, step, cmd_ready);
      end
      for (int i = 1; i < 4; i++) begin
         tick();
         checks++;
         if (value !== exp[i] || step !== 1 || done !== 0) begin
            failures++; $display("FAIL up_step%0d: value=%h step=%b done=%b, want %h 1 0", i, value, step, done, exp[i]);
         end
      end
      tick();
      checks++;
      if (done !== 1 || busy !== 1 || step !== 0 || value !== 8'h2) begin
         failures++; $display("FAIL up_done: done=%b busy=%b step=%b value=%h, want 1 1 0 02", done, busy, step, value);
      end
      tick();
      checks++;
      if (done !== 0 || cmd_ready !== 1 || busy !== 0 || value !== 8'h2) begin
         failures++; $display("FAIL up_idle: done=%b rdy=%b busy=%b value=%h, want 0 1 0 02", done, cmd_ready, busy, value);
      end
   endtask

   task automatic test_down;
      logic [7:0] exp [4] = '{8'h7, 8'h6, 8'h2, 8'h3};
      int steps = 0, dones = 0;
      issue(5, 2, 2);
      checks++;
      if (value !== 8'h7) begin
         failures++; $display("FAIL down_accept: value=%h, want 07", value);
      end
      for (int c = 1; c < 12; c++) begin
         tick();
         steps += int'(step);
         dones += int'(done);
         checks++;
         if (value !== exp[c/3]) begin
            failures++; $display("FAIL down_value c=%0d: value=%h, want %h", c, value, exp[c/3]);
         end
      end
      tick();
      checks++;
      if (done !== 1 || steps != 3 || dones != 0) begin
         failures++; $display("FAIL down_done: done=%b steps=%0d early_dones=%0d, want 1 3 0", done, steps, dones);
      end
      tick();
   endtask

   task automatic test_equal;
      issue(9, 9, 1);
      checks++;
      if (value !== 8'h0D) begin
         failures++; $display("FAIL eq_value: value=%h, want 0d", value);
      end
      tick();
      checks++;
      if (done !== 0 || step !== 0) begin
         failures++; $display("FAIL eq_wait: done=%b step=%b, want 0 0", done, step);
      end
      tick();
      checks++;
      if (done !== 1 || step !== 0 || value !== 8'h0D) begin
         failures++; $display("FAIL eq_done: done=%b step=%b value=%h, want 1 0 0d", done, step, value);
      end
      tick();
   endtask

   task automatic test_abort;
      issue(0, 255, 0);
      repeat (10) tick();
      checks++;
      if (value !== 8'h0F) begin
         failures++; $display("FAIL abort_pre: value=%h, want 0f", value);
      end
      @(negedge clk); abort = 1;
      tick();
      abort = 0;
      checks++;
      if (value !== 8'h0F || step !== 0 || done !== 0 || cmd_ready !== 1 || busy !== 0) begin
         failures++; $display("FAIL abort: value=%h step=%b done=%b rdy=%b busy=%b, want 0f 0 0 1 0", value, step, done, cmd_ready, busy);
      end
      repeat (3) tick();
      checks++;
      if (value !== 8'h0F || done !== 0 || busy !== 0) begin
         failures++; $display("FAIL abort_hold: value=%h done=%b busy=%b, want 0f 0 0", value, done, busy);
      end
      @(negedge clk);
      abort = 1; cmd_valid = 1; cmd_start = 3; cmd_end = 3; cmd_div = 0;
      tick();
      abort = 0; cmd_valid = 0;
      checks++;
      if (busy !== 1 || value !== 8'h02) begin
         failures++; $display("FAIL abort_idle_cmd: busy=%b value=%h, want 1 02", busy, value);
      end
      tick();
      checks++;
      if (done !== 1) begin
         failures++; $display("FAIL abort_idle_done: done=%b, want 1", done);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      cmd_valid = 1; cmd_start = 1; cmd_end = 2; cmd_div = 0;
      tick();
      @(negedge clk);
      cmd_start = 7; cmd_end = 6;
      checks++;
      if (value !== 8'h01 || cmd_ready !== 0) begin
         failures++; $display("FAIL b2b_first: value=%h rdy=%b, want 01 0", value, cmd_ready);
      end
      tick();
      checks++;
      if (value !== 8'h03 || step !== 1 || cmd_ready !== 0) begin
         failures++; $display("FAIL b2b_step: value=%h step=%b rdy=%b, want 03 1 0", value, step, cmd_ready);
      end
      tick();
      checks++;
      if (done !== 1 || cmd_ready !== 0 || value !== 8'h03) begin
         failures++; $display("FAIL b2b_done1: done=%b rdy=%b value=%h, want 1 0 03", done, cmd_ready, value);
      end
      tick();
      checks++;
      if (cmd_ready !== 1 || value !== 8'h03) begin
         failures++; $display("FAIL b2b_idle: rdy=%b value=%h, want 1 03", cmd_ready, value);
      end
      tick();
      cmd_valid = 0;
      checks++;
      if (busy !== 1 || value !== 8'h04) begin
         failures++; $display("FAIL b2b_second: busy=%b value=%h, want 1 04", busy, value);
      end
      tick();
      checks++;
      if (value !== 8'h05 || step !== 1) begin
         failures++; $display("FAIL b2b_second_step: value=%h step=%b, want 05 1", value, step);
      end
      tick();
      checks++;
      if (done !== 1) begin
         failures++; $display("FAIL b2b_done2: done=%b, want 1", done);
      end
      tick();
   endtask

   task automatic test_async_reset;
      issue(0, 255, 0);
      repeat (5) tick();
      #2 rst_n = 0;
      #1;
      checks++;
      if ({value, cmd_ready, busy, done, step} !== {8'h00, 4'b1000}) begin
         failures++;
         $display("FAIL async_reset: value=%h rdy=%b busy=%b done=%b step=%b, want 00 1 0 0 0", value, cmd_ready, busy, done, step);
      end
      @(negedge clk); rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_equal();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
